// File: rtl/rca_config_regfile.sv
// Per-RCA source/destination register-address tables, written by config-mode issue packets.
// Optional macro RCA_CONFIG_BYPASS_EN forwards a same-cycle write onto the queried cfg outputs.
module rca_config_regfile #(
  parameter int unsigned NUM_RCAS        = 4,
  parameter int unsigned NUM_READ_PORTS  = 5,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned ID_W            = 3,
  localparam int unsigned RCA_SEL_W      = $clog2(NUM_RCAS),
  localparam int unsigned PORT_SEL_W     = $clog2(NUM_READ_PORTS),
  localparam int unsigned ADDR_W         = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic [ID_W-1:0]                   issue_id,
  input  logic                              rca_config,
  input  logic [RCA_SEL_W-1:0]              rca_sel,
  input  logic [PORT_SEL_W-1:0]             w_port_sel,
  input  logic                              w_src_dest_port,
  input  logic [ADDR_W-1:0]                 w_reg_addr,
  input  logic [RCA_SEL_W-1:0]              query_sel,
  output logic [NUM_READ_PORTS*ADDR_W-1:0]  cfg_src_addrs,
  output logic [NUM_WRITE_PORTS*ADDR_W-1:0] cfg_dest_addrs,
  output logic                              cfg_valid,
  output logic                              wb_done,
  output logic [ID_W-1:0]                   wb_id,
  output logic                              wb_err,
  input  logic                              wb_ack
);

  logic [ADDR_W-1:0] src_tbl [NUM_RCAS][NUM_READ_PORTS];
  logic [ADDR_W-1:0] dst_tbl [NUM_RCAS][NUM_WRITE_PORTS];
  logic              accept;
  logic              illegal;
  logic              wr_en;
  logic              q_hit;

  // rst_n gates accept so nothing is taken (and cfg_valid stays high) while in reset
  assign issue_ready = ~wb_done | wb_ack;
  assign accept      = rst_n & issue_valid & issue_ready & rca_config;
  assign wr_en       = accept & ~illegal;
  assign q_hit       = wr_en & (rca_sel == query_sel);

  always_comb begin
    illegal = 1'b0;
    if (w_src_dest_port) illegal = (32'(w_port_sel) >= NUM_WRITE_PORTS);
    else                 illegal = (32'(w_port_sel) >= NUM_READ_PORTS);
  end

  // Table storage; slot decode by compare keeps narrow tables free of oversized indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++)  src_tbl[r][k] <= '0;
        for (int unsigned k = 0; k < NUM_WRITE_PORTS; k++) dst_tbl[r][k] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        if (rca_sel == RCA_SEL_W'(r)) begin
          for (int unsigned k = 0; k < NUM_READ_PORTS; k++)
            if (!w_src_dest_port && w_port_sel == PORT_SEL_W'(k)) src_tbl[r][k] <= w_reg_addr;
          for (int unsigned k = 0; k < NUM_WRITE_PORTS; k++)
            if (w_src_dest_port && w_port_sel == PORT_SEL_W'(k)) dst_tbl[r][k] <= w_reg_addr;
        end
      end
    end
  end

  // One-entry completion slot; a new accept in the ack cycle refills it directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_done <= 1'b0;
      wb_id   <= '0;
      wb_err  <= 1'b0;
    end else if (accept) begin
      wb_done <= 1'b1;
      wb_id   <= issue_id;
      wb_err  <= illegal;
    end else if (wb_ack) begin
      wb_done <= 1'b0;
      wb_id   <= '0;
      wb_err  <= 1'b0;
    end
  end

  always_comb begin
    cfg_src_addrs  = '0;
    cfg_dest_addrs = '0;
    for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
      cfg_src_addrs[ADDR_W*k +: ADDR_W] = src_tbl[query_sel][k];
`ifdef RCA_CONFIG_BYPASS_EN
      if (q_hit && !w_src_dest_port && w_port_sel == PORT_SEL_W'(k))
        cfg_src_addrs[ADDR_W*k +: ADDR_W] = w_reg_addr;
`endif
    end
    for (int unsigned k = 0; k < NUM_WRITE_PORTS; k++) begin
      cfg_dest_addrs[ADDR_W*k +: ADDR_W] = dst_tbl[query_sel][k];
`ifdef RCA_CONFIG_BYPASS_EN
      if (q_hit && w_src_dest_port && w_port_sel == PORT_SEL_W'(k))
        cfg_dest_addrs[ADDR_W*k +: ADDR_W] = w_reg_addr;
`endif
    end
  end

`ifdef RCA_CONFIG_BYPASS_EN
  assign cfg_valid = 1'b1;
`else
  assign cfg_valid = ~q_hit;
`endif

endmodule

// File: tb/tb_rca_config_regfile.sv
// Scoreboarded bench for rca_config_regfile: completions checked by a monitor, cfg outputs checked inline.
module tb_rca_config_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_id;
  logic        rca_config;
  logic [1:0]  rca_sel;
  logic [2:0]  w_port_sel;
  logic        w_src_dest_port;
  logic [4:0]  w_reg_addr;
  logic [1:0]  query_sel;
  logic [24:0] cfg_src_addrs;
  logic [9:0]  cfg_dest_addrs;
  logic        cfg_valid;
  logic        wb_done;
  logic [2:0]  wb_id;
  logic        wb_err;
  logic        wb_ack;

  typedef struct packed {
    logic [2:0] id;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  rca_config_regfile dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_id(issue_id), .rca_config(rca_config), .rca_sel(rca_sel), .w_port_sel(w_port_sel),
    .w_src_dest_port(w_src_dest_port), .w_reg_addr(w_reg_addr), .query_sel(query_sel),
    .cfg_src_addrs(cfg_src_addrs), .cfg_dest_addrs(cfg_dest_addrs), .cfg_valid(cfg_valid),
    .wb_done(wb_done), .wb_id(wb_id), .wb_err(wb_err), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] id, input logic cfg, input logic [1:0] sel,
                       input logic sd, input logic [2:0] port, input logic [4:0] addr);
    issue_valid     = 1'b1;
    issue_id        = id;
    rca_config      = cfg;
    rca_sel         = sel;
    w_src_dest_port = sd;
    w_port_sel      = port;
    w_reg_addr      = addr;
  endtask

  // Monitor: each consumed completion must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && wb_done && wb_ack) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_id), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_id", 32'(wb_id), 32'(e.id));
        chk("wb_err", 32'(wb_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_id = '0; rca_config = 1'b0; rca_sel = '0;
    w_port_sel = '0; w_src_dest_port = 1'b0; w_reg_addr = '0; query_sel = '0; wb_ack = 1'b0;

    @(negedge clk);
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_cfg_valid", 32'(cfg_valid), 1);
    chk("rst_wb_done", 32'(wb_done), 0);
    chk("rst_src", 32'(cfg_src_addrs), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic src write, rca 2 slot 3 = 17, acked on the first completion cycle
    query_sel = 2'd2;
    offer(3'd5, 1'b1, 2'd2, 1'b0, 3'd3, 5'd17);
    sb_q.push_back('{id: 3'd5, err: 1'b0});
    @(negedge clk);
`ifdef RCA_CONFIG_BYPASS_EN
    chk("t1_n_valid", 32'(cfg_valid), 1);
    chk("t1_n_fwd", 32'(cfg_src_addrs[19:15]), 17);
`else
    chk("t1_n_valid", 32'(cfg_valid), 0);
    chk("t1_n_old", 32'(cfg_src_addrs[19:15]), 0);
`endif
    tick();
    issue_valid = 1'b0; wb_ack = 1'b1;
    @(negedge clk);
    chk("t1_src", 32'(cfg_src_addrs[19:15]), 17);
    chk("t1_done", 32'(wb_done), 1);
    chk("t1_id", 32'(wb_id), 5);
    chk("t1_err", 32'(wb_err), 0);
    chk("t1_valid", 32'(cfg_valid), 1);
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    chk("t1_done_clr", 32'(wb_done), 0);
    chk("t1_ready", 32'(issue_ready), 1);
    tick();

    // Backpressure: completion held 4 cycles, second offer taken only in the ack cycle
    query_sel = 2'd0;
    offer(3'd3, 1'b1, 2'd0, 1'b0, 3'd0, 5'd7);
    sb_q.push_back('{id: 3'd3, err: 1'b0});
    tick();
    offer(3'd4, 1'b1, 2'd0, 1'b0, 3'd1, 5'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold_done", 32'(wb_done), 1);
      chk("t2_hold_id", 32'(wb_id), 3);
      chk("t2_hold_ready", 32'(issue_ready), 0);
      tick();
    end
    chk("t2_no_early_write", 32'(cfg_src_addrs[9:5]), 0);
    wb_ack = 1'b1;
    sb_q.push_back('{id: 3'd4, err: 1'b0});
    @(negedge clk);
    chk("t2_ack_ready", 32'(issue_ready), 1);
    tick();
    issue_valid = 1'b0; wb_ack = 1'b0;
    @(negedge clk);
    chk("t2_b2b_done", 32'(wb_done), 1);
    chk("t2_b2b_id", 32'(wb_id), 4);
    chk("t2_src", 32'(cfg_src_addrs[9:0]), 32'({5'd8, 5'd7}));
    tick();
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;

    // Illegal dest slot 2 and illegal src slot 5: dropped, completion flagged
    offer(3'd6, 1'b1, 2'd0, 1'b1, 3'd2, 5'd9);
    sb_q.push_back('{id: 3'd6, err: 1'b1});
    @(negedge clk);
    chk("t3_valid", 32'(cfg_valid), 1);
    tick();
    offer(3'd7, 1'b1, 2'd0, 1'b0, 3'd5, 5'd9);
    wb_ack = 1'b1;
    sb_q.push_back('{id: 3'd7, err: 1'b1});
    @(negedge clk);
    chk("t3_err", 32'(wb_err), 1);
    chk("t3_dest", 32'(cfg_dest_addrs), 0);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t3_src", 32'(cfg_src_addrs), 32'({5'd8, 5'd7}));
    tick();
    wb_ack = 1'b0;
    @(negedge clk);
    chk("t3_err_clr", 32'(wb_err), 0);

    // Use-mode offer: no state change, no completion
    tick();
    offer(3'd1, 1'b0, 2'd0, 1'b0, 3'd0, 5'd31);
    @(negedge clk);
    chk("t4_valid", 32'(cfg_valid), 1);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t4_done", 32'(wb_done), 0);
    chk("t4_src", 32'(cfg_src_addrs[4:0]), 7);

    // Same-RCA dest write visibility
    tick();
    query_sel = 2'd1;
    offer(3'd2, 1'b1, 2'd1, 1'b1, 3'd0, 5'd12);
    sb_q.push_back('{id: 3'd2, err: 1'b0});
    @(negedge clk);
`ifdef RCA_CONFIG_BYPASS_EN
    chk("t5_n_valid", 32'(cfg_valid), 1);
    chk("t5_n_dest", 32'(cfg_dest_addrs[4:0]), 12);
`else
    chk("t5_n_valid", 32'(cfg_valid), 0);
    chk("t5_n_dest", 32'(cfg_dest_addrs[4:0]), 0);
`endif
    tick();
    issue_valid = 1'b0; wb_ack = 1'b1;
    @(negedge clk);
    chk("t5_dest", 32'(cfg_dest_addrs[4:0]), 12);
    chk("t5_valid", 32'(cfg_valid), 1);
    tick();
    wb_ack = 1'b0;

    // Consecutive writes to one slot: last writer wins
    query_sel = 2'd3;
    offer(3'd0, 1'b1, 2'd3, 1'b0, 3'd4, 5'd20);
    sb_q.push_back('{id: 3'd0, err: 1'b0});
    tick();
    offer(3'd1, 1'b1, 2'd3, 1'b0, 3'd4, 5'd21);
    wb_ack = 1'b1;
    sb_q.push_back('{id: 3'd1, err: 1'b0});
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t6_lww", 32'(cfg_src_addrs[24:20]), 21);
    tick();
    wb_ack = 1'b0;

    // Asynchronous reset mid-handshake
    offer(3'd5, 1'b1, 2'd3, 1'b1, 3'd1, 5'd30);
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    chk("t7_pre_done", 32'(wb_done), 1);
    chk("t7_pre_dest", 32'(cfg_dest_addrs[9:5]), 30);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_done", 32'(wb_done), 0);
    chk("t7_id", 32'(wb_id), 0);
    chk("t7_err", 32'(wb_err), 0);
    chk("t7_src", 32'(cfg_src_addrs), 0);
    chk("t7_dest", 32'(cfg_dest_addrs), 0);
    chk("t7_ready", 32'(issue_ready), 1);
    chk("t7_valid", 32'(cfg_valid), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
